safe_ctrl_param: RTL and testbench

Parametrised keypad safe controller: the next generation of the safe control logic that sits between the keypad scanner and the lock/LED pins. Accepts one-cycle key strobes, compares a CODE_LEN-digit entry against a stored code, and drives lock/green/blue. Adds a runtime-programmable code, a failed-attempt lockout with a timer, and an optional auto-relock timeout.

---
 rtl/safe_ctrl_param.sv | 204 ++++++++++++++++++++
 tb/tb_safe_ctrl_param.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/safe_ctrl_param.sv
// rtl/safe_ctrl_param.sv - parametrised keypad safe controller with programmable code, lockout and auto-relock
module safe_ctrl_param #(
    parameter int                            CODE_LEN       = 4,
    parameter int                            DIGIT_W        = 4,
    parameter logic [CODE_LEN*DIGIT_W-1:0]   DEFAULT_CODE   = 16'h1234,
    parameter logic [DIGIT_W-1:0]            KEY_ENTER      = 4'hE,
    parameter logic [DIGIT_W-1:0]            KEY_CLEAR      = 4'hC,
    parameter logic [DIGIT_W-1:0]            KEY_PROG       = 4'hF,
    parameter int                            MAX_FAIL       = 3,
    parameter int                            LOCKOUT_CYCLES = 1024,
    parameter int                            OPEN_TIMEOUT   = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              key_valid,
    input  logic [DIGIT_W-1:0]                key_data,
    output logic                              lock,
    output logic                              green,
    output logic                              blue,
    output logic                              lockout,
    output logic [$clog2(MAX_FAIL+1)-1:0]     fail_count
);

    localparam int CODE_W    = CODE_LEN * DIGIT_W;
    localparam int CNT_W     = $clog2(CODE_LEN + 1);
    localparam int FAIL_W    = $clog2(MAX_FAIL + 1);
    localparam int TIMER_MAX = (LOCKOUT_CYCLES > OPEN_TIMEOUT) ? LOCKOUT_CYCLES : OPEN_TIMEOUT;
    localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

    localparam logic [CNT_W-1:0]   CNT_FULL  = CNT_W'(CODE_LEN);
    localparam logic [FAIL_W-1:0]  FAIL_MAX  = FAIL_W'(MAX_FAIL);
    localparam logic [TIMER_W-1:0] T_LOCKOUT = TIMER_W'(LOCKOUT_CYCLES);
    localparam logic [TIMER_W-1:0] T_OPEN    = TIMER_W'(OPEN_TIMEOUT);
    localparam logic [TIMER_W-1:0] T_ONE     = TIMER_W'(1);

    typedef enum logic [1:0] {
        S_LOCKED  = 2'd0,
        S_OPEN    = 2'd1,
        S_PROG    = 2'd2,
        S_LOCKOUT = 2'd3
    } state_t;

    state_t               state, state_nx;
    logic [CODE_W-1:0]    entry, entry_nx;
    logic [CODE_W-1:0]    code, code_nx;
    logic [CODE_W-1:0]    entry_shift;
    logic [CNT_W-1:0]     cnt, cnt_nx;
    logic                 ovf, ovf_nx;
    logic [FAIL_W-1:0]    fail, fail_nx;
    logic [TIMER_W-1:0]   timer, timer_nx;

    logic is_enter;
    logic is_clear;
    logic is_prog;
    logic is_digit;
    logic entry_full;
    logic match;

    // Key classification and entry-buffer helpers shared by LOCKED and PROG
    always_comb begin
        is_enter    = key_valid && (key_data == KEY_ENTER);
        is_clear    = key_valid && (key_data == KEY_CLEAR);
        is_prog     = key_valid && (key_data == KEY_PROG);
        is_digit    = key_valid && !((key_data == KEY_ENTER) ||
                                     (key_data == KEY_CLEAR) ||
                                     (key_data == KEY_PROG));
        entry_shift = (entry << DIGIT_W) | CODE_W'(key_data);
        entry_full  = (cnt == CNT_FULL) && !ovf;
        match       = entry_full && (entry == code);
    end

    // Next-state and datapath update; the shared timer serves both lockout and auto-relock
    always_comb begin
        state_nx = state;
        entry_nx = entry;
        cnt_nx   = cnt;
        ovf_nx   = ovf;
        code_nx  = code;
        fail_nx  = fail;
        timer_nx = timer;

        case (state)
            S_LOCKED: begin
                if (is_digit) begin
                    // Extra digits beyond CODE_LEN poison the entry instead of scrolling it
                    if (cnt == CNT_FULL) begin
                        ovf_nx = 1'b1;
                    end else begin
                        entry_nx = entry_shift;
                        cnt_nx   = cnt + CNT_W'(1);
                    end
                end else if (is_clear) begin
                    entry_nx = '0;
                    cnt_nx   = '0;
                    ovf_nx   = 1'b0;
                end else if (is_enter) begin
                    entry_nx = '0;
                    cnt_nx   = '0;
                    ovf_nx   = 1'b0;
                    if (match) begin
                        state_nx = S_OPEN;
                        fail_nx  = '0;
                        timer_nx = T_OPEN;
                    end else if ((fail + FAIL_W'(1)) >= FAIL_MAX) begin
                        state_nx = S_LOCKOUT;
                        fail_nx  = FAIL_MAX;
                        timer_nx = T_LOCKOUT;
                    end else begin
                        fail_nx  = fail + FAIL_W'(1);
                    end
                end
            end

            S_OPEN: begin
                // Expiry takes priority over any key arriving in the same cycle
                if (timer == T_ONE) begin
                    state_nx = S_LOCKED;
                    timer_nx = '0;
                end else begin
                    if (timer != '0) begin
                        timer_nx = timer - T_ONE;
                    end
                    if (is_enter) begin
                        state_nx = S_LOCKED;
                        timer_nx = '0;
                    end else if (is_prog) begin
                        state_nx = S_PROG;
                        entry_nx = '0;
                        cnt_nx   = '0;
                        ovf_nx   = 1'b0;
                        timer_nx = '0;
                    end
                end
            end

            S_PROG: begin
                if (is_digit) begin
                    if (cnt == CNT_FULL) begin
                        ovf_nx = 1'b1;
                    end else begin
                        entry_nx = entry_shift;
                        cnt_nx   = cnt + CNT_W'(1);
                    end
                end else if (is_clear || is_enter) begin
                    // Only a complete, non-overflowed entry replaces the code
                    if (is_enter && entry_full) begin
                        code_nx = entry;
                    end
                    state_nx = S_OPEN;
                    entry_nx = '0;
                    cnt_nx   = '0;
                    ovf_nx   = 1'b0;
                    timer_nx = T_OPEN;
                end
            end

            S_LOCKOUT: begin
                if (timer <= T_ONE) begin
                    state_nx = S_LOCKED;
                    fail_nx  = '0;
                    timer_nx = '0;
                end else begin
                    timer_nx = timer - T_ONE;
                end
            end

            default: begin
                state_nx = S_LOCKED;
            end
        endcase
    end

    // State, datapath and output registers; outputs decode the next state so they change with it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_LOCKED;
            entry   <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            code    <= DEFAULT_CODE;
            fail    <= '0;
            timer   <= '0;
            lock    <= 1'b1;
            green   <= 1'b0;
            blue    <= 1'b0;
            lockout <= 1'b0;
        end else begin
            state   <= state_nx;
            entry   <= entry_nx;
            cnt     <= cnt_nx;
            ovf     <= ovf_nx;
            code    <= code_nx;
            fail    <= fail_nx;
            timer   <= timer_nx;
            lock    <= !((state_nx == S_OPEN) || (state_nx == S_PROG));
            green   <= (state_nx == S_OPEN) || (state_nx == S_PROG);
            blue    <= (state_nx == S_PROG);
            lockout <= (state_nx == S_LOCKOUT);
        end
    end

    assign fail_count = fail;

endmodule

// File: tb/tb_safe_ctrl_param.sv
// tb/tb_safe_ctrl_param.sv - scoreboard bench for safe_ctrl_param
module tb_safe_ctrl_param;

    localparam int         CL        = 4;
    localparam int         MAXF      = 3;
    localparam logic [3:0] K_ENT     = 4'hE;
    localparam logic [3:0] K_CLR     = 4'hC;
    localparam logic [3:0] K_PRG     = 4'hF;
    localparam int         S_LOCKED  = 0;
    localparam int         S_OPEN    = 1;
    localparam int         S_PROG    = 2;
    localparam int         S_LOCKOUT = 3;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_data  = 4'h0;

    logic       lock0, green0, blue0, lockout0;
    logic [1:0] fail0;
    logic       lock1, green1, blue1, lockout1;
    logic [1:0] fail1;

    always #5 clk = ~clk;

    safe_ctrl_param dut0 (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_data   (key_data),
        .lock       (lock0),
        .green      (green0),
        .blue       (blue0),
        .lockout    (lockout0),
        .fail_count (fail0)
    );

    safe_ctrl_param #(
        .LOCKOUT_CYCLES (5),
        .OPEN_TIMEOUT   (20)
    ) dut1 (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_data   (key_data),
        .lock       (lock1),
        .green      (green1),
        .blue       (blue1),
        .lockout    (lockout1),
        .fail_count (fail1)
    );

    int n_checks = 0;
    int n_pass   = 0;

    int lk_len[2] = '{1024, 5};
    int to_len[2] = '{0, 20};

    int m_state[2];
    int m_buf[2][CL];
    int m_n[2];
    bit m_over[2];
    int m_code[2][CL];
    int m_fail[2];
    int m_age[2];

    logic [5:0] q0[$];
    logic [5:0] q1[$];

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [5:0] m_out(input int i);
        logic op;
        op = (m_state[i] == S_OPEN) || (m_state[i] == S_PROG);
        return {!op, op, m_state[i] == S_PROG, m_state[i] == S_LOCKOUT, 2'(m_fail[i])};
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            m_state[i] = S_LOCKED;
            m_n[i]     = 0;
            m_over[i]  = 1'b0;
            m_fail[i]  = 0;
            m_age[i]   = 0;
            m_code[i][0] = 1;
            m_code[i][1] = 2;
            m_code[i][2] = 3;
            m_code[i][3] = 4;
        end
    endtask

    task automatic m_clear(input int i);
        m_n[i]    = 0;
        m_over[i] = 1'b0;
    endtask

    task automatic m_digit(input int i, input int d);
        if (m_n[i] < CL) begin
            m_buf[i][m_n[i]] = d;
            m_n[i]++;
        end else begin
            m_over[i] = 1'b1;
        end
    endtask

    task automatic m_to_open(input int i);
        m_state[i] = S_OPEN;
        m_age[i]   = 0;
    endtask

    // Reference model: one call per clock edge; m_age counts edges since entering the current state
    task automatic m_step(input int i, input logic kv, input logic [3:0] kd);
        bit full;
        bit same;
        m_age[i]++;
        full = (m_n[i] == CL) && !m_over[i];
        case (m_state[i])
            S_LOCKOUT: begin
                if (m_age[i] == lk_len[i]) begin
                    m_state[i] = S_LOCKED;
                    m_fail[i]  = 0;
                end
            end
            S_OPEN: begin
                if (to_len[i] != 0 && m_age[i] == to_len[i]) m_state[i] = S_LOCKED;
                else if (kv && kd == K_ENT) m_state[i] = S_LOCKED;
                else if (kv && kd == K_PRG) begin
                    m_state[i] = S_PROG;
                    m_clear(i);
                end
            end
            S_PROG: begin
                if (kv) begin
                    if (kd == K_ENT) begin
                        if (full) for (int j = 0; j < CL; j++) m_code[i][j] = m_buf[i][j];
                        m_to_open(i);
                        m_clear(i);
                    end else if (kd == K_CLR) begin
                        m_to_open(i);
                        m_clear(i);
                    end else if (kd != K_PRG) begin
                        m_digit(i, int'(kd));
                    end
                end
            end
            default: begin
                if (kv) begin
                    if (kd == K_ENT) begin
                        same = full;
                        for (int j = 0; j < CL; j++) if (m_buf[i][j] != m_code[i][j]) same = 1'b0;
                        m_clear(i);
                        if (same) begin
                            m_to_open(i);
                            m_fail[i] = 0;
                        end else begin
                            m_fail[i]++;
                            if (m_fail[i] >= MAXF) begin
                                m_state[i] = S_LOCKOUT;
                                m_age[i]   = 0;
                            end
                        end
                    end else if (kd == K_CLR) begin
                        m_clear(i);
                    end else if (kd != K_PRG) begin
                        m_digit(i, int'(kd));
                    end
                end
            end
        endcase
    endtask

    task automatic step(input logic kv, input logic [3:0] kd);
        @(negedge clk);
        #1;
        key_valid = kv;
        key_data  = kd;
        m_step(0, kv, kd);
        m_step(1, kv, kd);
        q0.push_back(m_out(0));
        q1.push_back(m_out(1));
    endtask

    task automatic press(input logic [3:0] k);
        step(1'b1, k);
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) step(1'b0, 4'h0);
    endtask

    task automatic keys4(input logic [15:0] v);
        for (int j = 3; j >= 0; j--) press(v[j*4 +: 4]);
    endtask

    task automatic peek();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst       = 1'b0;
        key_valid = 1'b0;
        #1;
        check_eq("rst_out0", {lock0, green0, blue0, lockout0, fail0}, 6'b100000);
        check_eq("rst_out1", {lock1, green1, blue1, lockout1, fail1}, 6'b100000);
        m_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
    endtask

    // Scoreboard: pop one expectation per DUT per cycle, after the edge that produced it
    always @(negedge clk) begin
        if (q0.size() != 0) check_eq($sformatf("dut0_out@%0t", $time), {lock0, green0, blue0, lockout0, fail0}, q0.pop_front());
        if (q1.size() != 0) check_eq($sformatf("dut1_out@%0t", $time), {lock1, green1, blue1, lockout1, fail1}, q1.pop_front());
    end

    int r;

    initial begin
        m_reset();
        do_reset();

        keys4(16'h1234); press(K_ENT); peek();
        check_eq("open_lock", lock0, 1'b0);
        check_eq("open_green", green0, 1'b1);
        press(K_ENT); peek();
        check_eq("relock_lock", lock0, 1'b1);
        check_eq("relock_green", green0, 1'b0);

        press(4'h1); press(4'h2); press(4'h3); press(K_ENT); peek();
        check_eq("short_fail", fail0, 2'd1);
        keys4(16'h1234); press(4'h5); press(K_ENT); peek();
        check_eq("ovf_fail", fail0, 2'd2);
        check_eq("ovf_lock", lock0, 1'b1);

        keys4(16'h5555); press(K_ENT); peek();
        check_eq("lockout_on", lockout0, 1'b1);
        check_eq("lockout_fail_sat", fail0, 2'd3);
        keys4(16'h1234); press(K_ENT); peek();
        check_eq("lockout_ignore_lock", lock0, 1'b1);
        check_eq("lockout_ignore_lo", lockout0, 1'b1);
        idle(1018); peek();
        check_eq("lockout_last", lockout0, 1'b1);
        idle(1); peek();
        check_eq("lockout_end", lockout0, 1'b0);
        check_eq("lockout_end_fail", fail0, 2'd0);
        keys4(16'h1234); press(K_ENT); peek();
        check_eq("post_lockout_open", green0, 1'b1);

        press(K_PRG); peek();
        check_eq("prog_blue", blue0, 1'b1);
        keys4(16'h9876); press(K_ENT); peek();
        check_eq("prog_done_blue", blue0, 1'b0);
        check_eq("prog_done_green", green0, 1'b1);
        press(K_ENT);
        keys4(16'h1234); press(K_ENT); peek();
        check_eq("old_code_fail", fail0, 2'd1);
        check_eq("old_code_lock", lock0, 1'b1);
        keys4(16'h9876); press(K_ENT); peek();
        check_eq("new_code_open", green0, 1'b1);
        do_reset();
        keys4(16'h1234); press(K_ENT); peek();
        check_eq("reset_code_open", green0, 1'b1);

        press(K_PRG); press(4'h9); press(4'h8); press(K_ENT); peek();
        check_eq("prog_short_blue", blue0, 1'b0);
        check_eq("prog_short_green", green0, 1'b1);
        press(K_PRG); press(K_CLR); peek();
        check_eq("prog_clr_blue", blue0, 1'b0);
        check_eq("prog_clr_green", green0, 1'b1);
        press(K_ENT);
        keys4(16'h1234); press(K_ENT); peek();
        check_eq("code_kept_open", green0, 1'b1);

        press(K_ENT); press(K_ENT); peek();
        check_eq("zero_digit_fail", fail0, 2'd1);

        keys4(16'h1234); press(K_ENT);
        idle(19); peek();
        check_eq("timeout_before", lock1, 1'b0);
        press(K_PRG); peek();
        check_eq("timeout_lock", lock1, 1'b1);
        check_eq("timeout_key_dropped", blue1, 1'b0);
        check_eq("no_timeout_prog", blue0, 1'b1);
        press(K_CLR); press(K_ENT);

        repeat (60) begin
            r = $urandom_range(0, 3);
            case (r)
                0: begin
                    for (int j = 0; j < CL; j++) press(4'(m_code[0][j]));
                    press(K_ENT);
                end
                1: repeat ($urandom_range(0, 6)) press(4'($urandom_range(0, 15)));
                2: idle($urandom_range(1, 25));
                default: begin
                    case ($urandom_range(0, 2))
                        0:       press(K_ENT);
                        1:       press(K_CLR);
                        default: press(K_PRG);
                    endcase
                end
            endcase
        end
        do_reset();
        idle(2);

        @(negedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
